// File: rtl/row_select_decoder.sv
// row_select_decoder
// Registered one-hot select decoder with a built-in scan sequencer.
// Drives the row/column enables of the cell grid: either a directly loaded
// index, a single pass SEL_IN..LAST_SEL, or a continuously repeating pass.
// Every output is registered; the decode is taken from the next index so
// SEL_OUT lines up with CUR_SEL on the same cycle.

module row_select_decoder #(
  parameter int SEL_WIDTH = 2,
  parameter int LAST_SEL  = (2 ** SEL_WIDTH) - 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic                      load,
  input  logic [SEL_WIDTH-1:0]      sel_in,
  input  logic                      step,
  input  logic                      abort,
  output logic [(2**SEL_WIDTH)-1:0] sel_out,
  output logic [SEL_WIDTH-1:0]      cur_sel,
  output logic                      busy,
  output logic                      scan_done
);

  localparam int N = 2 ** SEL_WIDTH;

  // Final index of a pass, narrowed to index width. The parameter range is
  // limited to 0..N-1 so nothing is lost by the cast.
  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(LAST_SEL);

  // MODE encodings. 2'b11 falls through to direct behaviour.
  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_ONCE   = 2'b01;
  localparam logic [1:0] MODE_LOOP   = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SCAN_ONCE = 2'b01,
    SCAN_LOOP = 2'b10
  } state_t;

  state_t                 state_q,     state_d;
  logic [SEL_WIDTH-1:0]   cur_sel_q,   cur_sel_d;
  logic [N-1:0]           sel_out_q,   sel_out_d;
  logic                   busy_q,      busy_d;
  logic                   scan_done_q, scan_done_d;

  logic                   scanning;
  logic                   at_last;
  logic                   start_in_range;
  logic [SEL_WIDTH-1:0]   scan_start;

  // Helper terms shared by the next-state logic: whether a scan is live,
  // whether the current index is the pass end, and the clamped start index
  // (an out-of-range start restarts the pass from index 0).
  always_comb begin
    scanning       = (state_q != IDLE);
    at_last        = (cur_sel_q == LAST_IDX);
    start_in_range = (sel_in <= LAST_IDX);
    scan_start     = start_in_range ? sel_in : '0;
  end

  // Next-state logic for the sequencer; priority is abort, then load, then
  // step. Abort keeps the current index so the grid stays on the last row.
  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel_q;
    scan_done_d = 1'b0;

    if (abort && scanning) begin
      state_d = IDLE;
    end else if (load) begin
      unique case (mode)
        MODE_ONCE: begin
          cur_sel_d = scan_start;
          state_d   = SCAN_ONCE;
        end
        MODE_LOOP: begin
          cur_sel_d = scan_start;
          state_d   = SCAN_LOOP;
        end
        default: begin
          cur_sel_d = sel_in;
          state_d   = IDLE;
        end
      endcase
    end else if (step && scanning) begin
      if (!at_last) begin
        cur_sel_d = cur_sel_q + 1'b1;
      end else begin
        scan_done_d = 1'b1;
        if (state_q == SCAN_LOOP) begin
          cur_sel_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  // Registered status: busy follows the state we are about to enter.
  always_comb begin
    busy_d = (state_d != IDLE);
  end

  // One-hot decode of the next index, gated by the current output enable.
  always_comb begin
    sel_out_d = '0;
    for (int i = 0; i < N; i++) begin
      sel_out_d[i] = en && (cur_sel_d == SEL_WIDTH'(i));
    end
  end

  // State and output registers; reset clears everything asynchronously so a
  // scan interrupted by reset never reports completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_sel_q   <= '0;
      sel_out_q   <= '0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      sel_out_q   <= sel_out_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
    end
  end

  // Drive the ports straight from the registers.
  always_comb begin
    sel_out   = sel_out_q;
    cur_sel   = cur_sel_q;
    busy      = busy_q;
    scan_done = scan_done_q;
  end

endmodule

// File: tb/tb_row_select_decoder.sv
// Testbench for row_select_decoder.
// Two instances: a 2-bit decoder with the full range and a 3-bit decoder
// whose pass ends at index 5. A small reference model predicts each cycle's
// outputs; predictions are queued when stimulus is driven and popped when
// the registered outputs are sampled one edge later.

module tb_row_select_decoder;

  logic       clk;
  logic       rst_n;

  logic       aEn, aLoad, aStep, aAbort;
  logic [1:0] aMode;
  logic [1:0] aSelIn;
  logic [3:0] aSelOut;
  logic [1:0] aCurSel;
  logic       aBusy, aScanDone;

  logic       bEn, bLoad, bStep, bAbort;
  logic [1:0] bMode;
  logic [2:0] bSelIn;
  logic [7:0] bSelOut;
  logic [2:0] bCurSel;
  logic       bBusy, bScanDone;

  int nAsserts = 0;
  int nFails   = 0;

  typedef struct {
    string tag;
    int    dut;
    int    selOut;
    int    curSel;
    int    busy;
    int    scanDone;
  } exp_t;

  exp_t scoreboard[$];

  // Reference model state per instance: 0 idle, 1 single scan, 2 loop scan.
  int mState[2];
  int mCur[2];
  int mLast[2] = '{3, 5};

  row_select_decoder #(.SEL_WIDTH(2)) dutA (
    .clk(clk), .rst_n(rst_n), .en(aEn), .mode(aMode), .load(aLoad),
    .sel_in(aSelIn), .step(aStep), .abort(aAbort), .sel_out(aSelOut),
    .cur_sel(aCurSel), .busy(aBusy), .scan_done(aScanDone)
  );

  row_select_decoder #(.SEL_WIDTH(3), .LAST_SEL(5)) dutB (
    .clk(clk), .rst_n(rst_n), .en(bEn), .mode(bMode), .load(bLoad),
    .sel_in(bSelIn), .step(bStep), .abort(bAbort), .sel_out(bSelOut),
    .cur_sel(bCurSel), .busy(bBusy), .scan_done(bScanDone)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareVal(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    nAsserts++;
    assert (obs === expv) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mState[d] = 0;
      mCur[d]   = 0;
    end
  endtask

  // Advance the model one edge for instance d and queue the expected outputs.
  task automatic modelAdvance(input int d, input string tag, input bit e, input int md,
                              input bit ld, input int sel, input bit st, input bit ab);
    exp_t x;
    int   done = 0;
    if (ab && mState[d] != 0) begin
      mState[d] = 0;
    end else if (ld) begin
      if (md == 1 || md == 2) begin
        mCur[d]   = (sel <= mLast[d]) ? sel : 0;
        mState[d] = md;
      end else begin
        mCur[d]   = sel;
        mState[d] = 0;
      end
    end else if (st && mState[d] != 0) begin
      if (mCur[d] < mLast[d]) begin
        mCur[d] = mCur[d] + 1;
      end else begin
        done = 1;
        if (mState[d] == 2) mCur[d] = 0;
        else                mState[d] = 0;
      end
    end
    x.tag      = tag;
    x.dut      = d;
    x.selOut   = e ? (1 << mCur[d]) : 0;
    x.curSel   = mCur[d];
    x.busy     = (mState[d] != 0) ? 1 : 0;
    x.scanDone = done;
    scoreboard.push_back(x);
  endtask

  task automatic checkOutput();
    exp_t       x;
    logic [7:0] oSel, oCur, oBusy, oDone;
    if (scoreboard.size() == 0) begin
      compareVal("scoreboard_empty", 8'd0, 8'd1);
      return;
    end
    x = scoreboard.pop_front();
    if (x.dut == 0) begin
      oSel = {4'b0, aSelOut}; oCur = {6'b0, aCurSel};
      oBusy = {7'b0, aBusy};  oDone = {7'b0, aScanDone};
    end else begin
      oSel = bSelOut;         oCur = {5'b0, bCurSel};
      oBusy = {7'b0, bBusy};  oDone = {7'b0, bScanDone};
    end
    compareVal({x.tag, ".sel_out"},   oSel,  8'(x.selOut));
    compareVal({x.tag, ".cur_sel"},   oCur,  8'(x.curSel));
    compareVal({x.tag, ".busy"},      oBusy, 8'(x.busy));
    compareVal({x.tag, ".scan_done"}, oDone, 8'(x.scanDone));
  endtask

  // Drive one cycle of stimulus into instance d, predict, then check after the edge.
  task automatic applyStimulus(input int d, input string tag, input bit e, input int md,
                               input bit ld, input int sel, input bit st, input bit ab);
    if (d == 0) begin
      aEn = e; aMode = md[1:0]; aLoad = ld; aSelIn = sel[1:0]; aStep = st; aAbort = ab;
    end else begin
      bEn = e; bMode = md[1:0]; bLoad = ld; bSelIn = sel[2:0]; bStep = st; bAbort = ab;
    end
    modelAdvance(d, tag, e, md, ld, sel, st, ab);
    @(posedge clk);
    #1;
    checkOutput();
    if (d == 0) begin
      aLoad = 1'b0; aStep = 1'b0; aAbort = 1'b0;
    end else begin
      bLoad = 1'b0; bStep = 1'b0; bAbort = 1'b0;
    end
  endtask

  task automatic checkAllZero(input string tag);
    compareVal({tag, ".a_sel_out"}, {4'b0, aSelOut}, 8'd0);
    compareVal({tag, ".a_cur_sel"}, {6'b0, aCurSel}, 8'd0);
    compareVal({tag, ".a_busy"},    {7'b0, aBusy},   8'd0);
    compareVal({tag, ".a_done"},    {7'b0, aScanDone}, 8'd0);
    compareVal({tag, ".b_sel_out"}, bSelOut,         8'd0);
    compareVal({tag, ".b_cur_sel"}, {5'b0, bCurSel}, 8'd0);
    compareVal({tag, ".b_busy"},    {7'b0, bBusy},   8'd0);
    compareVal({tag, ".b_done"},    {7'b0, bScanDone}, 8'd0);
  endtask

  initial begin
    aEn = 1'b1; aMode = 2'b00; aLoad = 1'b0; aSelIn = '0; aStep = 1'b0; aAbort = 1'b0;
    bEn = 1'b1; bMode = 2'b00; bLoad = 1'b0; bSelIn = '0; bStep = 1'b0; bAbort = 1'b0;
    rst_n = 1'b0;
    modelReset();

    // Reset held across edges: everything stays zero.
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset_held");
    rst_n = 1'b1;
    #2;
    checkAllZero("released_before_edge");

    // First edge after release shows bit 0 with EN high.
    applyStimulus(0, "first_edge", 1, 0, 0, 0, 0, 0);

    // Direct mode, EN gating, mode 11 as direct.
    applyStimulus(0, "direct_2",    1, 0, 1, 2, 0, 0);
    applyStimulus(0, "direct_3",    1, 0, 1, 3, 0, 0);
    applyStimulus(0, "en_low",      0, 0, 0, 0, 0, 0);
    applyStimulus(0, "en_high",     1, 0, 0, 0, 0, 0);
    applyStimulus(0, "mode11_load", 1, 3, 1, 1, 0, 0);
    applyStimulus(0, "step_idle",   1, 0, 0, 0, 1, 0);

    // Single scan from 1 to 3, then a step after completion.
    applyStimulus(0, "once_load",  1, 1, 1, 1, 0, 0);
    applyStimulus(0, "once_step1", 1, 1, 0, 0, 1, 0);
    applyStimulus(0, "once_step2", 1, 1, 0, 0, 1, 0);
    applyStimulus(0, "once_step3", 1, 1, 0, 0, 1, 0);
    applyStimulus(0, "once_after", 1, 1, 0, 0, 1, 0);
    applyStimulus(0, "once_quiet", 1, 1, 0, 0, 0, 0);

    // Continuous scan on the 3-bit instance with the pass ending at 5.
    applyStimulus(1, "loop_load",  1, 2, 1, 4, 0, 0);
    applyStimulus(1, "loop_step1", 1, 2, 0, 0, 1, 0);
    applyStimulus(1, "loop_step2", 1, 2, 0, 0, 1, 0);
    applyStimulus(1, "loop_step3", 1, 2, 0, 0, 1, 0);
    applyStimulus(1, "loop_step4", 1, 2, 0, 0, 1, 0);
    applyStimulus(1, "loop_hold",  1, 2, 0, 0, 0, 0);

    // Out-of-range start, load beats step, abort beats load, idle abort.
    applyStimulus(1, "oor_start",   1, 1, 1, 7, 0, 0);
    applyStimulus(1, "load_step",   1, 1, 1, 3, 1, 0);
    applyStimulus(1, "abort_load",  1, 0, 1, 1, 0, 1);
    applyStimulus(1, "abort_idle",  1, 0, 0, 0, 0, 1);
    applyStimulus(1, "start_last",  1, 1, 1, 5, 0, 0);
    applyStimulus(1, "last_step",   1, 1, 0, 0, 1, 0);

    // Mode changes during a single scan are ignored until the next load.
    applyStimulus(1, "mchg_load", 1, 1, 1, 3, 0, 0);
    applyStimulus(1, "mchg_s1",   1, 2, 0, 0, 1, 0);
    applyStimulus(1, "mchg_s2",   0, 2, 0, 0, 1, 0);
    applyStimulus(1, "mchg_s3",   1, 0, 0, 0, 1, 0);
    applyStimulus(1, "mchg_s4",   1, 2, 0, 0, 1, 0);

    // Asynchronous reset in the middle of a continuous scan.
    applyStimulus(1, "rst_load",  1, 2, 1, 2, 0, 0);
    applyStimulus(1, "rst_step",  1, 2, 0, 0, 1, 0);
    bStep = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    modelReset();
    #1;
    rst_n = 1'b1;
    bStep = 1'b0;
    applyStimulus(1, "rst_step_ignored", 1, 2, 0, 0, 1, 0);
    applyStimulus(1, "rst_abort_idle",   1, 2, 0, 0, 0, 1);

    if (scoreboard.size() != 0) begin
      compareVal("scoreboard_leftover", 8'(scoreboard.size()), 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/row_select_decoder.md
# row_select_decoder

Parametrised, registered one-hot select decoder with a built-in scan sequencer, used to drive row/column enables of the cell grid. It generalises the fixed 2-to-4 decode to 2**SEL_WIDTH outputs. Besides direct (loaded) selection, it can step through indices SEL_IN..LAST_SEL once, or cycle continuously, pulsing a done flag at the end of each pass. It sits between the grid controller and the cell array's row enables.

## Interface
- SEL_WIDTH, default 2: index width; number of outputs N = 2**SEL_WIDTH; legal range 1..6.
- LAST_SEL, default 2**SEL_WIDTH-1: final index of a scan pass; must satisfy 0 <= LAST_SEL <= N-1.
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  output enable; when low, SEL_OUT is forced to zero; internal state is unaffected.
- MODE  input  2  00 direct, 01 single scan, 10 continuous scan, 11 treated as direct; sampled only on LOAD.
- LOAD  input  1  capture SEL_IN and MODE; in a scan mode, starts a scan.
- SEL_IN  input  SEL_WIDTH  index to select (direct) or start index (scan).
- STEP  input  1  advance the scan index by one; ignored when not busy.
- ABORT  input  1  stop the scan immediately.
- SEL_OUT  output  N  registered one-hot decode of CUR_SEL, gated by EN.
- CUR_SEL  output  SEL_WIDTH  registered current index.
- BUSY  output  1  high while a scan is in progress.
- SCAN_DONE  output  1  single-cycle pulse at the end of a scan pass.

## Operation
- State machine:
  - IDLE: BUSY=0.
  - SCAN_ONCE: BUSY=1.
  - SCAN_LOOP: BUSY=1.
- Input priority each cycle: ABORT > LOAD > STEP.
- ABORT:
  - State goes to IDLE and CUR_SEL holds its value.
  - No SCAN_DONE pulse.
  - When idle, ABORT has no effect.
- LOAD in direct mode (MODE 00/11):
  - CUR_SEL <= SEL_IN; state goes to IDLE.
  - Any scan in progress is cancelled without SCAN_DONE.
- LOAD in a scan mode (01/10):
  - CUR_SEL <= SEL_IN if SEL_IN <= LAST_SEL, else 0.
  - State goes to SCAN_ONCE (01) or SCAN_LOOP (10).
  - LOAD while BUSY restarts the scan from the new start index.
- STEP in a scan state:
  - If CUR_SEL < LAST_SEL, then CUR_SEL <= CUR_SEL+1.
  - If CUR_SEL == LAST_SEL in SCAN_ONCE: CUR_SEL holds, SCAN_DONE=1 for one cycle, state goes to IDLE.
  - If CUR_SEL == LAST_SEL in SCAN_LOOP: CUR_SEL <= 0, SCAN_DONE=1 for one cycle, state stays in SCAN_LOOP.
- STEP in IDLE is ignored.
- MODE changes during a scan are ignored until the next LOAD.
- SEL_OUT[i] = EN && (CUR_SEL == i).
  - SEL_OUT is registered; it is computed from the next value of CUR_SEL and the current EN.
  - At most one bit of SEL_OUT is set.
- Index arithmetic is unsigned SEL_WIDTH bits. The compare against LAST_SEL guarantees the increment never overflows.

## Timing
- Reset (RST_N low, asynchronous):
  - CUR_SEL=0, SEL_OUT=0, BUSY=0, SCAN_DONE=0, state IDLE.
  - After reset release, SEL_OUT stays 0 until the first clock edge. After that edge it shows bit 0 if EN=1.
- Latency:
  - LOAD or STEP sampled at edge k → CUR_SEL, SEL_OUT and BUSY are updated after edge k (1 cycle).
  - EN sampled at edge k → SEL_OUT is gated or ungated after edge k.
- SCAN_DONE is asserted after the same edge that consumes the final STEP, and is low on the following edge unless that edge also completes a pass.
- Back-to-back STEP (every cycle) is supported: one index per cycle, no bubbles.
- Reset mid-scan aborts with no SCAN_DONE; all outputs go to reset values asynchronously.
- Simultaneous LOAD and STEP: LOAD wins and the STEP is dropped.
- Simultaneous ABORT and LOAD: ABORT wins.

## Test plan
- Reset and direct mode (SEL_WIDTH=2, EN=1): hold reset → all outputs 0; release, then LOAD SEL_IN=2 MODE=00 → next cycle SEL_OUT=0100, CUR_SEL=2, BUSY=0.
- EN gating: CUR_SEL=3, drop EN → next cycle SEL_OUT=0000 with CUR_SEL still 3; raise EN → SEL_OUT=1000.
- Single scan: LOAD SEL_IN=1 MODE=01, then STEP on 3 consecutive cycles → SEL_OUT goes 0010, 0100, 1000. The third STEP gives SCAN_DONE=1 for one cycle, BUSY=0, CUR_SEL=3. A further STEP → no change.
- Continuous scan with partial range (SEL_WIDTH=3, LAST_SEL=5): LOAD SEL_IN=4 MODE=10, STEP on 4 cycles → CUR_SEL goes 5, 0, 1, 2. SCAN_DONE pulses only on the 5→0 step. BUSY stays 1 throughout.
- Out-of-range start and priority (SEL_WIDTH=3, LAST_SEL=5): LOAD SEL_IN=7 MODE=01 → CUR_SEL=0. Then LOAD SEL_IN=3 together with STEP → CUR_SEL=3. Then ABORT together with LOAD → IDLE, CUR_SEL=3, no SCAN_DONE.
- Async reset mid-scan: assert RST_N low between edges during SCAN_LOOP → outputs go to 0 immediately, no SCAN_DONE pulse; after release, STEP is ignored (IDLE).
